// File: rtl/serie_paralelo_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver: idle/comma character,
// default comma-run length and the receiver FSM state encoding.
package serie_paralelo_rx_pkg;

   localparam logic [7:0]  COMMA_CHAR = 8'hBC;
   localparam int unsigned BC_REQ_DEF = 4;

   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      COUNT_BC = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

endpackage

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: bit-slides onto the comma character, waits for
// a run of aligned commas, then delivers each non-comma byte with a strobe.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   HUNT     | sliding search for a comma on every edge
//   COUNT_BC | aligned; counting consecutive commas at byte boundaries
//   ACTIVE   | link up; non-comma bytes delivered (left only by reset)
module serie_paralelo_rx
   import serie_paralelo_rx_pkg::*;
#(
   parameter logic [7:0]  COMMA  = COMMA_CHAR,
   parameter int unsigned BC_REQ = BC_REQ_DEF
)(
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_inS,
   output logic [7:0] data_outP,
   output logic       valid_out,
   output logic       active
);

   localparam logic [3:0] BC_REQ_W = 4'(BC_REQ);

   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [3:0] bc_cnt;
   logic [7:0] next_byte;
   logic       is_comma;
   logic       boundary;

   assign next_byte = {sr[6:0], data_inS};
   assign is_comma  = (next_byte == COMMA);
   assign boundary  = (bit_cnt == 3'd7);

   always_ff @(posedge clk_8f or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         sr        <= 8'h00;
         bit_cnt   <= 3'd0;
         bc_cnt    <= 4'd0;
         data_outP <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         sr        <= next_byte;
         bit_cnt   <= bit_cnt + 3'd1;
         valid_out <= 1'b0;
         case (state)
            HUNT: begin
               if (is_comma) begin
                  // Lock edge: the matched comma defines the byte phase.
                  bit_cnt <= 3'd0;
                  bc_cnt  <= 4'd1;
                  if (BC_REQ_W == 4'd1) begin
                     state  <= ACTIVE;
                     active <= 1'b1;
                  end else begin
                     state <= COUNT_BC;
                  end
               end
            end
            COUNT_BC: begin
               if (boundary) begin
                  if (is_comma) begin
                     bc_cnt <= bc_cnt + 4'd1;
                     if (bc_cnt + 4'd1 == BC_REQ_W) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     state  <= HUNT;
                     bc_cnt <= 4'd0;
                  end
               end
            end
            ACTIVE: begin
               if (boundary && !is_comma) begin
                  data_outP <= next_byte;
                  valid_out <= 1'b1;
               end
            end
            default: begin
               state  <= HUNT;
               bc_cnt <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Directed bench for serie_paralelo_rx: alignment, comma-run qualification,
// byte delivery and asynchronous reset behaviour.
module tb_serie_paralelo_rx;

   logic       clk_8f;
   logic       reset;
   logic       data_inS;
   logic [7:0] data_outP;
   logic       valid_out;
   logic       active;

   int checks = 0;
   int errors = 0;

   serie_paralelo_rx dut (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_inS  (data_inS),
      .data_outP (data_outP),
      .valid_out (valid_out),
      .active    (active)
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one bit, let one edge sample it, then look just after the edge.
   task automatic send_bit(input logic b);
      data_inS = b;
      @(posedge clk_8f);
      #1;
   endtask

   // MSB first; valid_out must stay low on the first seven bits, and the
   // outputs after the eighth bit must match the hand-computed values.
   task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_v,
                            input logic [7:0] exp_d, input logic exp_act);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i > 0) chk({tag, "_midvalid"}, {7'd0, valid_out}, 8'd0);
      end
      chk({tag, "_valid"},  {7'd0, valid_out}, {7'd0, exp_v});
      chk({tag, "_data"},   data_outP, exp_d);
      chk({tag, "_active"}, {7'd0, active}, {7'd0, exp_act});
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      @(posedge clk_8f);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      data_inS = 1'b0;

      // Reset held with random serial data
      for (int i = 0; i < 3; i++) begin
         data_inS = 1'($urandom_range(0, 1));
         @(posedge clk_8f);
         #1;
         chk("rst_data",   data_outP, 8'h00);
         chk("rst_valid",  {7'd0, valid_out}, 8'd0);
         chk("rst_active", {7'd0, active}, 8'd0);
      end
      reset = 1'b0;

      // Aligned commas from bit 1: active after the 4th, then two data bytes
      send_byte("t1_bc1", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t1_bc2", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t1_bc3", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t1_bc4", 8'hBC, 1'b0, 8'h00, 1'b1);
      send_byte("t1_d55", 8'h55, 1'b1, 8'h55, 1'b1);
      send_byte("t1_dA3", 8'hA3, 1'b1, 8'hA3, 1'b1);
      send_bit(1'b0);
      chk("t1_after_valid", {7'd0, valid_out}, 8'd0);

      // Three junk bits ahead of the comma run
      pulse_reset();
      send_bit(1'b1); chk("t2_junk0", {7'd0, valid_out}, 8'd0);
      send_bit(1'b0); chk("t2_junk1", {7'd0, valid_out}, 8'd0);
      send_bit(1'b1); chk("t2_junk2", {7'd0, active}, 8'd0);
      send_byte("t2_bc1", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t2_bc2", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t2_bc3", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t2_bc4", 8'hBC, 1'b0, 8'h00, 1'b1);
      send_byte("t2_d3C", 8'h3C, 1'b1, 8'h3C, 1'b1);

      // Broken comma run, then a complete one
      pulse_reset();
      send_byte("t3_bc1",  8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc2",  8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc3",  8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_brk",  8'h00, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc1b", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc2b", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc3b", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t3_bc4b", 8'hBC, 1'b0, 8'h00, 1'b1);
      send_byte("t3_d77",  8'h77, 1'b1, 8'h77, 1'b1);

      // Comma between data bytes on an active link
      send_byte("t4_d11", 8'h11, 1'b1, 8'h11, 1'b1);
      send_byte("t4_bc",  8'hBC, 1'b0, 8'h11, 1'b1);
      send_byte("t4_d22", 8'h22, 1'b1, 8'h22, 1'b1);

      // Asynchronous reset while the strobe is high
      send_byte("t5_d33", 8'h33, 1'b1, 8'h33, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("t5_async_valid",  {7'd0, valid_out}, 8'd0);
      chk("t5_async_active", {7'd0, active}, 8'd0);
      chk("t5_async_data",   data_outP, 8'h00);
      @(posedge clk_8f);
      #1 reset = 1'b0;
      send_byte("t5_d5A", 8'h5A, 1'b0, 8'h00, 1'b0);
      send_byte("t5_d66", 8'h66, 1'b0, 8'h00, 1'b0);
      send_byte("t5_bc1", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t5_bc2", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t5_bc3", 8'hBC, 1'b0, 8'h00, 1'b0);
      send_byte("t5_bc4", 8'hBC, 1'b0, 8'h00, 1'b1);
      send_byte("t5_d99", 8'h99, 1'b1, 8'h99, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
